// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
//   Bundles every bus-side signal of the single-port RAM arbiter:
//     - data side (coherence control):  cc_ramREN/WEN/addr/store in,
//                                       cc_ramload/cc_ramwait out
//     - instruction side (per CPU):      iREN/iaddr in, iload/iwait out
//     - memory side:                     ramREN/WEN/addr/store out,
//                                        ramload/ramstate in
//   Modports:
//     slave  : the arbiter's view (requests in, RAM commands out)
//     master : the environment's view (requesters plus memory model)
//   Parameter CPUS sets the number of instruction-fetch requesters.
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
  parameter int CPUS = 2
);
  // data side
  logic                   cc_ramREN;
  logic                   cc_ramWEN;
  logic [31:0]            cc_ramaddr;
  logic [31:0]            cc_ramstore;
  logic [31:0]            cc_ramload;
  logic                   cc_ramwait;
  // instruction side, one word_t per CPU
  logic [CPUS-1:0]        iREN;
  logic [CPUS-1:0][31:0]  iaddr;
  logic [CPUS-1:0][31:0]  iload;
  logic [CPUS-1:0]        iwait;
  // memory side
  logic                   ramREN;
  logic                   ramWEN;
  logic [31:0]            ramaddr;
  logic [31:0]            ramstore;
  logic [31:0]            ramload;
  logic [1:0]             ramstate;

  modport slave (
    input  cc_ramREN, cc_ramWEN, cc_ramaddr, cc_ramstore,
    output cc_ramload, cc_ramwait,
    input  iREN, iaddr,
    output iload, iwait,
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport master (
    output cc_ramREN, cc_ramWEN, cc_ramaddr, cc_ramstore,
    input  cc_ramload, cc_ramwait,
    output iREN, iaddr,
    input  iload, iwait,
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//   Single-port RAM arbiter sitting behind coherence control. It merges the
//   data-side RAM requests with per-CPU instruction fetches onto the single
//   ramREN/ramWEN/ramaddr/ramstore port of the memory model.
//     - data traffic has priority over instruction fetches
//     - instruction fetches rotate round-robin across CPUs
//     - a starvation counter lets a pending fetch beat data after
//       STARVE_LIMIT consecutive data grants
//   Ports:
//     CLK   : clock, rising edge
//     nRST  : asynchronous active-low reset
//     bus   : ram_arbiter_if.slave (data side, per-CPU fetch side, RAM side)
//   Parameters:
//     CPUS         : number of instruction-fetch requesters
//     STARVE_LIMIT : data grants a pending fetch tolerates before it wins
//   Every bus output is combinational from the registered state and grant,
//   so an asynchronous reset drops the RAM enables immediately.
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int CPUS         = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           CLK,
  input  logic           nRST,
  ram_arbiter_if.slave   bus
);

  localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   gnt_cpu;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   starve_cnt;

  logic               data_req;
  logic               any_ireq;
  logic               ram_done;
  logic               data_may_win;

  // ---------------------------------------------------------------------
  // helpers
  // ---------------------------------------------------------------------

  // first requester at or after ptr, wrapping modulo CPUS
  function automatic logic [IDX_W-1:0] rr_pick(input logic [CPUS-1:0]  req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < CPUS; k++) begin
      idx  = (int'(ptr) + k) % CPUS;
      cand = IDX_W'(idx);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // grant index + 1, modulo CPUS
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= CPUS - 1)
      return '0;
    else
      return idx + 1'b1;
  endfunction

  // starvation counter increment that saturates at STARVE_LIMIT
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= STARVE_MAX)
      return STARVE_MAX;
    else
      return cnt + 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // request decode
  // ---------------------------------------------------------------------
  assign data_req = bus.cc_ramREN | bus.cc_ramWEN;
  assign any_ireq = |bus.iREN;
  assign ram_done = (ramstate_t'(bus.ramstate) == ACCESS);

  // Data keeps priority until the pending fetch has starved. If the fetch
  // that built up the count has since gone away, nobody is left to take
  // the turn, so data must not be blocked by a stale count.
  assign data_may_win = (starve_cnt < STARVE_MAX) || !any_ireq;

  // ---------------------------------------------------------------------
  // arbitration FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= ARB;
      gnt_cpu    <= '0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (data_req && data_may_win) begin
            state <= DATA;
            // one more data win while a fetch is waiting
            if (any_ireq)
              starve_cnt <= sat_inc(starve_cnt);
          end else if (any_ireq) begin
            state      <= INSTR;
            gnt_cpu    <= rr_pick(bus.iREN, rr_ptr);
            starve_cnt <= '0;
          end
        end
        DATA: begin
          // a dropped request abandons the transfer without completion;
          // BUSY/FREE/ERROR simply hold the grant
          if (!data_req || ram_done)
            state <= ARB;
        end
        INSTR: begin
          if (!bus.iREN[gnt_cpu]) begin
            // fetch withdrawn early: give up, keep the rotation where it was
            state <= ARB;
          end else if (ram_done) begin
            state  <= ARB;
            rr_ptr <= next_idx(gnt_cpu);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // output steering
  // ---------------------------------------------------------------------
  logic                  ram_ren_c;
  logic                  ram_wen_c;
  logic [31:0]           ram_addr_c;
  logic [31:0]           ram_store_c;
  logic [31:0]           cc_load_c;
  logic                  cc_wait_c;
  logic [CPUS-1:0][31:0] iload_c;
  logic [CPUS-1:0]       iwait_c;

  always_comb begin
    ram_ren_c   = 1'b0;
    ram_wen_c   = 1'b0;
    ram_addr_c  = '0;
    ram_store_c = '0;
    cc_load_c   = '0;
    cc_wait_c   = 1'b1;
    iload_c     = '0;
    iwait_c     = '1;
    case (state)
      DATA: begin
        ram_addr_c  = bus.cc_ramaddr;
        ram_store_c = bus.cc_ramstore;
        ram_wen_c   = bus.cc_ramWEN;
        // read and write together: the write wins, the read is masked
        ram_ren_c   = bus.cc_ramREN & ~bus.cc_ramWEN;
        cc_load_c   = bus.ramload;
        cc_wait_c   = ~(ram_done && data_req);
      end
      INSTR: begin
        ram_ren_c        = 1'b1;
        ram_addr_c       = bus.iaddr[gnt_cpu];
        iload_c[gnt_cpu] = bus.ramload;
        iwait_c[gnt_cpu] = ~(ram_done && bus.iREN[gnt_cpu]);
      end
      default: ;
    endcase
  end

  assign bus.ramREN     = ram_ren_c;
  assign bus.ramWEN     = ram_wen_c;
  assign bus.ramaddr    = ram_addr_c;
  assign bus.ramstore   = ram_store_c;
  assign bus.cc_ramload = cc_load_c;
  assign bus.cc_ramwait = cc_wait_c;
  assign bus.iload      = iload_c;
  assign bus.iwait      = iwait_c;

  // ---------------------------------------------------------------------
  // invariants
  // ---------------------------------------------------------------------
  logic [CPUS:0] wait_lo;
  assign wait_lo = ~{iwait_c, cc_wait_c};

  // only one requester can be completing in any cycle
  a_one_done: assert property (@(posedge CLK) disable iff (!nRST)
    $onehot0(wait_lo));

  // the RAM is never asked to read and write at once
  a_no_rw: assert property (@(posedge CLK) disable iff (!nRST)
    !(ram_ren_c && ram_wen_c));

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//   Self-checking bench for ram_arbiter (CPUS=2, STARVE_LIMIT=8).
//   The memory model returns ramaddr ^ KEY as read data; ramstate is driven
//   directly by each scenario. Expected completions are queued when the
//   request is driven; a negedge monitor records every completion the DUT
//   signals and each scenario compares the two queues in order.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam logic [31:0] KEY    = 32'h5A5A_0000;
  localparam logic [1:0]  FREE   = 2'd0;
  localparam logic [1:0]  BUSY   = 2'd1;
  localparam logic [1:0]  ACCESS = 2'd2;
  localparam logic [1:0]  ERROR  = 2'd3;

  typedef struct {
    int          src;   // -1 data side, otherwise CPU index
    logic [31:0] data;  // load word for reads, store word for writes
  } xfer_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  int compared = 0;
  int failed   = 0;

  xfer_t exp_q[$];
  xfer_t obs_q[$];

  ram_arbiter_if #(.CPUS(2)) bus();

  ram_arbiter #(.CPUS(2), .STARVE_LIMIT(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // memory model: read data derived from the address being driven
  assign bus.ramload = bus.ramaddr ^ KEY;

  // completion monitor
  always @(negedge CLK) begin : mon
    int    nlow;
    xfer_t o;
    if (nRST) begin
      nlow   = 0;
      o.src  = -2;
      o.data = '0;
      if (bus.cc_ramwait === 1'b0) begin
        nlow++;
        o.src  = -1;
        o.data = bus.ramWEN ? bus.ramstore : bus.cc_ramload;
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.iwait[i] === 1'b0) begin
          nlow++;
          o.src  = i;
          o.data = bus.iload[i];
        end
      end
      if (nlow > 0) begin
        compared++;
        if (nlow != 1) begin
          failed++;
          $display("FAIL one_wait_low: got %0d waits low, required 1", nlow);
        end else begin
          obs_q.push_back(o);
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cc_ramREN   = 1'b0;
    bus.cc_ramWEN   = 1'b0;
    bus.cc_ramaddr  = '0;
    bus.cc_ramstore = '0;
    bus.iREN        = '0;
    bus.iaddr       = '0;
    bus.ramstate    = FREE;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    repeat (2) sample();
    compared++; if (bus.ramREN !== 1'b0) begin failed++; $display("FAIL rst_ramREN: got %b, required 0", bus.ramREN); end
    compared++; if (bus.ramWEN !== 1'b0) begin failed++; $display("FAIL rst_ramWEN: got %b, required 0", bus.ramWEN); end
    compared++; if (bus.ramaddr !== 32'h0) begin failed++; $display("FAIL rst_ramaddr: got %h, required 0", bus.ramaddr); end
    compared++; if (bus.ramstore !== 32'h0) begin failed++; $display("FAIL rst_ramstore: got %h, required 0", bus.ramstore); end
    compared++; if (bus.cc_ramwait !== 1'b1) begin failed++; $display("FAIL rst_cc_ramwait: got %b, required 1", bus.cc_ramwait); end
    compared++; if (bus.iwait !== 2'b11) begin failed++; $display("FAIL rst_iwait: got %b, required 11", bus.iwait); end
    compared++; if (bus.cc_ramload !== 32'h0) begin failed++; $display("FAIL rst_cc_ramload: got %h, required 0", bus.cc_ramload); end
    compared++; if (bus.iload !== 64'h0) begin failed++; $display("FAIL rst_iload: got %h, required 0", bus.iload); end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_data_read();
    int    ren_cnt;
    xfer_t e, o;
    ren_cnt = 0;
    next_cyc();
    bus.cc_ramREN  = 1'b1;
    bus.cc_ramaddr = 32'h0000_0100;
    bus.ramstate   = FREE;
    e.src = -1; e.data = 32'h0000_0100 ^ KEY; exp_q.push_back(e);
    sample();
    compared++; if (bus.ramREN !== 1'b0) begin failed++; $display("FAIL rd_arb_ren: got %b, required 0", bus.ramREN); end
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      bus.ramstate = (k < 2) ? BUSY : ACCESS;
      sample();
      if (bus.ramREN === 1'b1) ren_cnt++;
      compared++;
      if (bus.cc_ramwait !== ((k < 2) ? 1'b1 : 1'b0)) begin
        failed++; $display("FAIL rd_wait_c%0d: got %b, required %b", k, bus.cc_ramwait, (k < 2) ? 1'b1 : 1'b0);
      end
      compared++;
      if (bus.ramaddr !== 32'h0000_0100) begin
        failed++; $display("FAIL rd_addr_c%0d: got %h, required 00000100", k, bus.ramaddr);
      end
    end
    next_cyc();
    idle_inputs();
    sample();
    compared++; if (bus.ramREN !== 1'b0) begin failed++; $display("FAIL rd_back_arb: got %b, required 0", bus.ramREN); end
    compared++; if (ren_cnt != 3) begin failed++; $display("FAIL rd_ren_cycles: got %0d, required 3", ren_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); compared++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL rd_sb: got no completion, required src %0d data %h", e.src, e.data); end
      else begin o = obs_q.pop_front(); if (o.src != e.src || o.data !== e.data) begin failed++; $display("FAIL rd_sb: got src %0d data %h, required src %0d data %h", o.src, o.data, e.src, e.data); end end
    end
    compared++; if (obs_q.size() != 0) begin failed++; $display("FAIL rd_extra: got %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_instr_rr();
    logic [1:0] exp_iw [6];
    xfer_t      e, o;
    exp_iw = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};
    next_cyc();
    bus.iREN     = 2'b11;
    bus.iaddr[0] = 32'h0000_0200;
    bus.iaddr[1] = 32'h0000_0300;
    bus.ramstate = ACCESS;
    e.src = 0; e.data = 32'h0000_0200 ^ KEY; exp_q.push_back(e);
    e.src = 1; e.data = 32'h0000_0300 ^ KEY; exp_q.push_back(e);
    e.src = 0; e.data = 32'h0000_0200 ^ KEY; exp_q.push_back(e);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cyc();
      sample();
      compared++;
      if (bus.iwait !== exp_iw[c]) begin
        failed++; $display("FAIL rr_iwait_c%0d: got %b, required %b", c, bus.iwait, exp_iw[c]);
      end
      if (c == 1) begin
        compared++;
        if (bus.iload[1] !== 32'h0) begin failed++; $display("FAIL rr_ungranted_load: got %h, required 0", bus.iload[1]); end
      end
    end
    next_cyc();
    idle_inputs();
    sample();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); compared++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL rr_sb: got no completion, required src %0d data %h", e.src, e.data); end
      else begin o = obs_q.pop_front(); if (o.src != e.src || o.data !== e.data) begin failed++; $display("FAIL rr_sb: got src %0d data %h, required src %0d data %h", o.src, o.data, e.src, e.data); end end
    end
    compared++; if (obs_q.size() != 0) begin failed++; $display("FAIL rr_extra: got %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_starvation();
    xfer_t e, o;
    next_cyc();
    bus.cc_ramWEN   = 1'b1;
    bus.cc_ramaddr  = 32'h0000_0400;
    bus.cc_ramstore = 32'hCAFE_0001;
    bus.iREN        = 2'b10;
    bus.iaddr[1]    = 32'h0000_0500;
    bus.ramstate    = ACCESS;
    for (int g = 0; g < 8; g++) begin
      e.src = -1; e.data = 32'hCAFE_0001; exp_q.push_back(e);
    end
    e.src = 1; e.data = 32'h0000_0500 ^ KEY; exp_q.push_back(e);
    e.src = -1; e.data = 32'hCAFE_0001; exp_q.push_back(e);
    e.src = -1; e.data = 32'hCAFE_0001; exp_q.push_back(e);
    sample();
    for (int c = 1; c <= 21; c++) begin
      next_cyc();
      sample();
      if (c == 17) begin
        compared++;
        if (bus.iwait !== 2'b01) begin failed++; $display("FAIL st_instr_grant: got %b, required 01", bus.iwait); end
      end else if (c == 15 || c == 19) begin
        compared++;
        if (bus.ramWEN !== 1'b1) begin failed++; $display("FAIL st_data_c%0d: got %b, required 1", c, bus.ramWEN); end
      end
    end
    next_cyc();
    idle_inputs();
    sample();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); compared++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL st_sb: got no completion, required src %0d data %h", e.src, e.data); end
      else begin o = obs_q.pop_front(); if (o.src != e.src || o.data !== e.data) begin failed++; $display("FAIL st_sb: got src %0d data %h, required src %0d data %h", o.src, o.data, e.src, e.data); end end
    end
    compared++; if (obs_q.size() != 0) begin failed++; $display("FAIL st_extra: got %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_write_wins();
    xfer_t e, o;
    next_cyc();
    bus.cc_ramREN   = 1'b1;
    bus.cc_ramWEN   = 1'b1;
    bus.cc_ramaddr  = 32'h0000_0600;
    bus.cc_ramstore = 32'h1234_5678;
    bus.ramstate    = ACCESS;
    e.src = -1; e.data = 32'h1234_5678; exp_q.push_back(e);
    sample();
    next_cyc();
    sample();
    compared++; if (bus.ramWEN !== 1'b1) begin failed++; $display("FAIL ww_wen: got %b, required 1", bus.ramWEN); end
    compared++; if (bus.ramREN !== 1'b0) begin failed++; $display("FAIL ww_ren: got %b, required 0", bus.ramREN); end
    compared++; if (bus.ramstore !== 32'h1234_5678) begin failed++; $display("FAIL ww_store: got %h, required 12345678", bus.ramstore); end
    compared++; if (bus.ramaddr !== 32'h0000_0600) begin failed++; $display("FAIL ww_addr: got %h, required 00000600", bus.ramaddr); end
    next_cyc();
    idle_inputs();
    sample();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); compared++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL ww_sb: got no completion, required src %0d data %h", e.src, e.data); end
      else begin o = obs_q.pop_front(); if (o.src != e.src || o.data !== e.data) begin failed++; $display("FAIL ww_sb: got src %0d data %h, required src %0d data %h", o.src, o.data, e.src, e.data); end end
    end
    compared++; if (obs_q.size() != 0) begin failed++; $display("FAIL ww_extra: got %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    next_cyc();
    bus.iREN     = 2'b01;
    bus.iaddr[0] = 32'h0000_0700;
    bus.ramstate = BUSY;
    sample();
    next_cyc();
    sample();
    compared++; if (bus.ramREN !== 1'b1) begin failed++; $display("FAIL rm_busy_ren: got %b, required 1", bus.ramREN); end
    nRST = 1'b0;
    #1;
    compared++; if (bus.ramREN !== 1'b0) begin failed++; $display("FAIL rm_async_ren: got %b, required 0", bus.ramREN); end
    compared++; if (bus.iwait !== 2'b11) begin failed++; $display("FAIL rm_async_iwait: got %b, required 11", bus.iwait); end
    compared++; if (bus.ramaddr !== 32'h0) begin failed++; $display("FAIL rm_async_addr: got %h, required 0", bus.ramaddr); end
    next_cyc();
    nRST = 1'b1;
    sample();
    compared++; if (bus.ramREN !== 1'b0) begin failed++; $display("FAIL rm_arb_after: got %b, required 0", bus.ramREN); end
    next_cyc();
    idle_inputs();
    sample();
    compared++; if (obs_q.size() != 0) begin failed++; $display("FAIL rm_no_completion: got %0d completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_error_hold();
    xfer_t e, o;
    next_cyc();
    bus.cc_ramREN  = 1'b1;
    bus.cc_ramaddr = 32'h0000_0800;
    bus.ramstate   = ERROR;
    e.src = -1; e.data = 32'h0000_0800 ^ KEY; exp_q.push_back(e);
    sample();
    for (int c = 1; c <= 5; c++) begin
      next_cyc();
      sample();
      compared++;
      if (bus.cc_ramwait !== 1'b1) begin failed++; $display("FAIL er_hold_c%0d: got %b, required 1", c, bus.cc_ramwait); end
    end
    next_cyc();
    bus.ramstate = ACCESS;
    sample();
    compared++; if (bus.cc_ramwait !== 1'b0) begin failed++; $display("FAIL er_done: got %b, required 0", bus.cc_ramwait); end
    next_cyc();
    idle_inputs();
    sample();
    compared++; if (bus.cc_ramwait !== 1'b1) begin failed++; $display("FAIL er_once: got %b, required 1", bus.cc_ramwait); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); compared++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL er_sb: got no completion, required src %0d data %h", e.src, e.data); end
      else begin o = obs_q.pop_front(); if (o.src != e.src || o.data !== e.data) begin failed++; $display("FAIL er_sb: got src %0d data %h, required src %0d data %h", o.src, o.data, e.src, e.data); end end
    end
    compared++; if (obs_q.size() != 0) begin failed++; $display("FAIL er_extra: got %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_data_read();
    test_instr_rr();
    test_starvation();
    test_write_wins();
    test_reset_mid();
    test_error_hold();
    repeat (2) next_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion of all scenarios");
    $fatal(1, "watchdog expired");
  end

endmodule
